// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch-stage bus signals: redirect input, instruction memory
// read port and the valid/ready handshake toward decode.
// master = instruction_fetch side, slave = memory/branch/decode side.
interface instruction_fetch_if;
    logic        pc_ld;
    logic [31:0] pc_in;
    logic        imem_cs;
    logic        imem_rd;
    logic        imem_wr;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        addr_err;

    modport master (
        input  pc_ld, pc_in, imem_dout, ir_ready,
        output imem_cs, imem_rd, imem_wr, imem_addr,
        output ir_out, pc_out, ir_valid, addr_err
    );

    modport slave (
        output pc_ld, pc_in, imem_dout, ir_ready,
        input  imem_cs, imem_rd, imem_wr, imem_addr,
        input  ir_out, pc_out, ir_valid, addr_err
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, reads the instruction memory
// and buffers {pc+4, instr} pairs in a 2-entry queue toward decode.
// Redirects (pc_ld) flush the queue and restart fetch at the new target.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN enables a sticky addr_err
// flag on misaligned redirect targets; undefined, addr_err is constant 0.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  reset_n,
    instruction_fetch_if.master  bus
);

    logic [31:0] fetch_pc_r;
    logic [1:0]  count_r;
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [31:0] fifo_ir_r [2];
    logic [31:0] fifo_pc_r [2];
    logic [31:0] hold_ir_r;
    logic [31:0] hold_pc_r;
    logic        addr_err_r;

    logic        ir_valid_s;
    logic        pop_s;
    logic        fetch_s;
    logic [1:0]  count_nxt_s;
    logic [31:0] head_ir_s;
    logic [31:0] head_pc_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] redirect_pc_s;

    // Handshake qualification, queue occupancy update and head selection.
    always_comb begin
        ir_valid_s    = (count_r != 2'd0);
        pop_s         = ir_valid_s & bus.ir_ready & ~bus.pc_ld;
        // Memory must stay deselected while reset is held.
        fetch_s       = reset_n & ~bus.pc_ld & ((count_r < 2'd2) | pop_s);
        pc_plus4_s    = fetch_pc_r + 32'd4;
        redirect_pc_s = {bus.pc_in[31:2], 2'b00};
        count_nxt_s   = count_r;
        case ({fetch_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
        // An empty queue keeps showing the last head that decode saw.
        if (ir_valid_s) begin
            head_ir_s = fifo_ir_r[rd_ptr_r];
            head_pc_s = fifo_pc_r[rd_ptr_r];
        end else begin
            head_ir_s = hold_ir_r;
            head_pc_s = hold_pc_r;
        end
    end

    // Drive the memory port and the decode-side outputs.
    always_comb begin
        bus.imem_cs   = fetch_s;
        bus.imem_rd   = fetch_s;
        bus.imem_wr   = 1'b0;
        bus.imem_addr = fetch_pc_r;
        bus.ir_out    = head_ir_s;
        bus.pc_out    = head_pc_s;
        bus.ir_valid  = ir_valid_s;
        bus.addr_err  = addr_err_r;
    end

    // Fetch PC, queue pointers and occupancy; redirect overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r <= RESET_PC;
            count_r    <= 2'd0;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
        end else if (bus.pc_ld) begin
            fetch_pc_r <= redirect_pc_s;
            count_r    <= 2'd0;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (fetch_s) begin
                fetch_pc_r <= pc_plus4_s;
                wr_ptr_r   <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    // Queue storage: capture the fetched word with its return address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_ir_r[i] <= 32'h0000_0000;
                fifo_pc_r[i] <= 32'h0000_0000;
            end
        end else if (fetch_s) begin
            fifo_ir_r[wr_ptr_r] <= bus.imem_dout;
            fifo_pc_r[wr_ptr_r] <= pc_plus4_s;
        end
    end

    // Remember the head shown this cycle so it persists once the queue drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_ir_r <= 32'h0000_0000;
            hold_pc_r <= 32'h0000_0000;
        end else begin
            hold_ir_r <= head_ir_s;
            hold_pc_r <= head_pc_s;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Sticky flag for redirect targets that are not word aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_err_r <= 1'b0;
        end else if (bus.pc_ld && (bus.pc_in[1:0] != 2'b00)) begin
            addr_err_r <= 1'b1;
        end
    end
`else
    // Low target bits are dropped without reporting.
    logic unused_pc_lsb_s;
    assign unused_pc_lsb_s = ^bus.pc_in[1:0];
    assign addr_err_r      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [1024];

    instruction_fetch_if bus ();
    instruction_fetch_if wbus ();

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.master)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .bus(wbus.master)
    );

    assign bus.imem_dout  = (bus.imem_cs & bus.imem_rd) ? mem[bus.imem_addr[11:2]] : 32'hzzzz_zzzz;
    assign wbus.imem_dout = (wbus.imem_cs & wbus.imem_rd) ? mem[wbus.imem_addr[11:2]] : 32'hzzzz_zzzz;

`ifdef IFETCH_ALIGN_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.ir_ready = 1'b0;
        bus.pc_ld    = 1'b0;
        reset_n      = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid: got %b want 0", bus.ir_valid); end
        checks++; if (bus.ir_out !== 32'h0) begin errors++; $display("FAIL reset_ir_out: got %h want 0", bus.ir_out); end
        checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h want 0", bus.pc_out); end
        checks++; if ({bus.imem_cs, bus.imem_rd, bus.imem_wr} !== 3'b000) begin errors++; $display("FAIL reset_mem_ctl: got %b want 000", {bus.imem_cs, bus.imem_rd, bus.imem_wr}); end
        checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b want 0", bus.addr_err); end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_cs !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_fetch: cs %b addr %h want 1 00000000", bus.imem_cs, bus.imem_addr); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL first_fetch_valid: got %b want 0", bus.ir_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_ir [3];
        logic [31:0] exp_pc [3];
        exp_ir[0] = 32'h1111_1111; exp_ir[1] = 32'h2222_2222; exp_ir[2] = 32'h3333_3333;
        exp_pc[0] = 32'h0000_0004; exp_pc[1] = 32'h0000_0008; exp_pc[2] = 32'h0000_000C;
        bus.ir_ready = 1'b1;
        apply_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir_out !== exp_ir[i] || bus.pc_out !== exp_pc[i]) begin
                errors++;
                $display("FAIL stream_%0d: valid %b ir %h pc %h want 1 %h %h", i, bus.ir_valid, bus.ir_out, bus.pc_out, exp_ir[i], exp_pc[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          nfetch;
        logic [31:0] exp_ir [4];
        logic [31:0] exp_pc [4];
        exp_ir[0] = 32'h1111_1111; exp_ir[1] = 32'h2222_2222; exp_ir[2] = 32'h3333_3333; exp_ir[3] = 32'hA000_0003;
        exp_pc[0] = 32'h0000_0004; exp_pc[1] = 32'h0000_0008; exp_pc[2] = 32'h0000_000C; exp_pc[3] = 32'h0000_0010;
        nfetch = 0;
        bus.ir_ready = 1'b0;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.imem_cs) begin
                checks++;
                if (bus.imem_addr !== 32'(nfetch * 4)) begin errors++; $display("FAIL bp_addr_%0d: got %h want %h", nfetch, bus.imem_addr, 32'(nfetch * 4)); end
                nfetch++;
            end
            if (c >= 1) begin
                checks++;
                if (bus.ir_out !== 32'h1111_1111) begin errors++; $display("FAIL bp_hold_%0d: got %h want 11111111", c, bus.ir_out); end
            end
            tick();
        end
        checks++; if (nfetch != 2) begin errors++; $display("FAIL bp_fetch_count: got %0d want 2", nfetch); end
        @(negedge clk);
        checks++; if (bus.imem_cs !== 1'b0) begin errors++; $display("FAIL bp_cs_idle: got %b want 0", bus.imem_cs); end
        tick();
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir_out !== exp_ir[i] || bus.pc_out !== exp_pc[i]) begin
                errors++;
                $display("FAIL bp_release_%0d: valid %b ir %h pc %h want 1 %h %h", i, bus.ir_valid, bus.ir_out, bus.pc_out, exp_ir[i], exp_pc[i]);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        bus.ir_ready = 1'b0;
        apply_reset();
        tick();
        tick();
        bus.ir_ready = 1'b1;
        bus.pc_ld    = 1'b1;
        bus.pc_in    = 32'h0000_0100;
        @(negedge clk);
        checks++; if (bus.imem_cs !== 1'b0) begin errors++; $display("FAIL redir_no_fetch: cs %b want 0", bus.imem_cs); end
        tick();
        bus.pc_ld = 1'b0;
        @(negedge clk);
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: valid %b want 0", bus.ir_valid); end
        checks++; if (bus.imem_cs !== 1'b1 || bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_addr: cs %b addr %h want 1 00000100", bus.imem_cs, bus.imem_addr); end
        checks++; if (bus.ir_out !== 32'h1111_1111) begin errors++; $display("FAIL redir_hold: ir %h want 11111111", bus.ir_out); end
        tick();
        @(negedge clk);
        checks++;
        if (bus.ir_valid !== 1'b1 || bus.pc_out !== 32'h0000_0104 || bus.ir_out !== 32'hA000_0040) begin
            errors++;
            $display("FAIL redir_target: valid %b ir %h pc %h want 1 a0000040 00000104", bus.ir_valid, bus.ir_out, bus.pc_out);
        end
    endtask

    task automatic test_misaligned();
        bus.ir_ready = 1'b1;
        bus.pc_ld    = 1'b0;
        apply_reset();
        tick();
        bus.pc_ld = 1'b1;
        bus.pc_in = 32'h0000_0102;
        @(negedge clk);
        checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL mis_pre_err: got %b want 0", bus.addr_err); end
        tick();
        bus.pc_ld = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL mis_addr: got %h want 00000100", bus.imem_addr); end
        checks++; if (bus.addr_err !== EXP_ERR) begin errors++; $display("FAIL mis_err: got %b want %b", bus.addr_err, EXP_ERR); end
        tick();
        bus.pc_ld = 1'b1;
        bus.pc_in = 32'h0000_0200;
        @(negedge clk);
        checks++; if (bus.pc_out !== 32'h0000_0104) begin errors++; $display("FAIL mis_pc_out: got %h want 00000104", bus.pc_out); end
        tick();
        bus.pc_ld = 1'b0;
        @(negedge clk);
        checks++; if (bus.addr_err !== EXP_ERR || bus.imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL mis_sticky: err %b addr %h want %b 00000200", bus.addr_err, bus.imem_addr, EXP_ERR); end
    endtask

    task automatic test_wrap();
        apply_reset();
        @(negedge clk);
        checks++; if (wbus.imem_addr !== 32'hFFFF_FFFC || wbus.imem_cs !== 1'b1) begin errors++; $display("FAIL wrap_first_addr: cs %b addr %h want 1 fffffffc", wbus.imem_cs, wbus.imem_addr); end
        tick();
        @(negedge clk);
        checks++; if (wbus.pc_out !== 32'h0000_0000 || wbus.ir_out !== 32'hA000_03FF || wbus.ir_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc_out: valid %b ir %h pc %h want 1 a00003ff 00000000", wbus.ir_valid, wbus.ir_out, wbus.pc_out); end
        checks++; if (wbus.imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next_addr: got %h want 00000000", wbus.imem_addr); end
        tick();
        @(negedge clk);
        checks++; if (wbus.ir_out !== 32'h1111_1111 || wbus.pc_out !== 32'h0000_0004) begin errors++; $display("FAIL wrap_second: ir %h pc %h want 11111111 00000004", wbus.ir_out, wbus.pc_out); end
    endtask

    task automatic test_async_reset();
        bus.ir_ready = 1'b0;
        bus.pc_ld    = 1'b0;
        apply_reset();
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.ir_valid !== 1'b1 || bus.imem_cs !== 1'b0) begin errors++; $display("FAIL ar_full: valid %b cs %b want 1 0", bus.ir_valid, bus.imem_cs); end
        tick();
        bus.ir_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.ir_valid !== 1'b0 || bus.imem_cs !== 1'b0 || bus.imem_rd !== 1'b0) begin errors++; $display("FAIL ar_immediate: valid %b cs %b rd %b want 0 0 0", bus.ir_valid, bus.imem_cs, bus.imem_rd); end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_cs !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL ar_restart: cs %b addr %h want 1 00000000", bus.imem_cs, bus.imem_addr); end
        tick();
        @(negedge clk);
        checks++; if (bus.ir_out !== 32'h1111_1111 || bus.pc_out !== 32'h0000_0004) begin errors++; $display("FAIL ar_first: ir %h pc %h want 11111111 00000004", bus.ir_out, bus.pc_out); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        reset_n       = 1'b0;
        bus.pc_ld     = 1'b0;
        bus.pc_in     = 32'h0;
        bus.ir_ready  = 1'b0;
        wbus.pc_ld    = 1'b0;
        wbus.pc_in    = 32'h0;
        wbus.ir_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the MIPS instruction unit: owns the fetch PC and drives the read-only port of the 4096x8 big-endian instruction memory. Each fetched word is captured together with its PC+4 in a 2-entry prefetch queue. The queue feeds the decode stage over a valid/ready handshake. Branch and jump redirects flush the queue and restart fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset; must be word aligned
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pc_ld  in  1  redirect request from branch/jump logic
- pc_in  in  32  redirect target address
- imem_cs  out  1  memory chip select
- imem_rd  out  1  memory read enable
- imem_wr  out  1  memory write enable, constant 0
- imem_addr  out  32  byte address of the word being fetched
- imem_dout  in  32  memory read data, valid combinationally while cs & rd; high-Z otherwise
- ir_out  out  32  instruction at queue head
- pc_out  out  32  PC+4 of the instruction at queue head
- ir_valid  out  1  queue head holds a valid instruction
- ir_ready  in  1  decode accepts the head this cycle
- addr_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State:
  - fetch_pc (32 bits)
  - 2-entry FIFO of {pc_plus4, instr} with rd_ptr, wr_ptr and count (0..2)
- pop = ir_valid & ir_ready & !pc_ld.
- fetch = !pc_ld & (count < 2 | pop).
- During a fetch cycle:
  - imem_cs = imem_rd = 1; imem_addr = fetch_pc.
  - At the edge: push {fetch_pc+4, imem_dout}; fetch_pc <= fetch_pc + 4.
- When not fetching: imem_cs = imem_rd = 0 and imem_addr holds fetch_pc. imem_dout is ignored and never captured.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- count == 2 with no pop: no fetch issued, fetch_pc held.
- count == 0: ir_valid = 0. ir_out/pc_out hold their last value (0 after reset). Decode ignores them.
- Redirect (pc_ld = 1), highest priority:
  - At the edge: count <= 0, pointers <= 0, fetch_pc <= {pc_in[31:2], 2'b00}.
  - No fetch and no pop that cycle, even if ir_ready = 1.
- Arithmetic: fetch_pc and pc_plus4 are 32-bit modulo, so 32'hFFFF_FFFC + 4 = 0. Upper address bits are passed through unmodified; the memory uses only the low 12 bits.
- ir_out/pc_out are driven from the FIFO head entry, a registered path.

## Timing
- Reset (async assert, any time, including mid-fetch):
  - fetch_pc = RESET_PC; count = 0; ir_valid = 0; ir_out = 0; pc_out = 0; addr_err = 0.
  - imem_cs = imem_rd = imem_wr = 0 while reset_n = 0.
- First fetch is issued in the first cycle after reset_n deasserts. ir_valid rises after the next edge (1-cycle latency).
- Redirect latency: pc_ld sampled at edge E, target fetched in cycle E..E+1, ir_valid = 1 after edge E+1. The first instruction after a redirect therefore reaches decode 2 cycles after pc_ld is asserted.
- Steady state with ir_ready held 1: one instruction per cycle, no bubbles.
- ir_ready dropped: the queue fills in at most 2 cycles, then fetch stops. ir_out is stable until popped.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - A redirect with pc_in[1:0] != 0 sets addr_err at the edge.
  - addr_err stays set until reset.
  - The target is still forced to word alignment.
- IFETCH_ALIGN_CHECK_EN undefined: addr_err is constant 0 and pc_in[1:0] are silently cleared.

## Test plan
- Reset then ir_ready = 1, memory preloaded with words 0x11111111, 0x22222222, 0x33333333 at addresses 0x000/0x004/0x008 -> ir_out sequence 0x11111111, 0x22222222, 0x33333333 on consecutive cycles; pc_out 0x004, 0x008, 0x00C.
- Backpressure: ir_ready = 0 for 5 cycles after reset -> exactly 2 fetches (imem_addr 0x000, 0x004), then imem_cs = 0. ir_out stays 0x11111111. On release, no instruction is lost or duplicated.
- Redirect: pc_ld = 1, pc_in = 0x100 while the queue holds 2 entries and ir_ready = 1 -> no pop that cycle, queue flushed, next imem_addr = 0x100. ir_valid = 1 one edge later with pc_out = 0x104.
- Misaligned redirect pc_in = 0x102 -> fetch at 0x100. addr_err = 1 with IFETCH_ALIGN_CHECK_EN defined, 0 without.
- Wrap: RESET_PC = 32'hFFFF_FFFC -> first pc_out = 0x0000_0000, next imem_addr = 0x0000_0000.
- Async reset asserted mid-stream with the queue full -> ir_valid = 0 and imem_cs = 0 immediately. After release, fetch restarts at RESET_PC.
